// File: rtl/fetch_pkg.sv
// Shared types and helpers for the multi-wide fetch queue.
package fetch_pkg;

    localparam int unsigned FETCH_INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Pointer/counter width that never collapses to zero bits.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_ring.sv
// Circular buffer of fetch entries with FetchW-wide write/read ports and a flush.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int unsigned FetchW = 2,
    parameter int unsigned Depth  = 8,
    localparam int unsigned PtrW  = ptr_width(Depth),
    localparam int unsigned CntW  = ptr_width(Depth + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [CntW-1:0]           wr_n_i,
    input  fetch_entry_t [FetchW-1:0] wr_data_i,
    input  logic [CntW-1:0]           rd_m_i,
    output fetch_entry_t [FetchW-1:0] rd_data_o,
    output logic [CntW-1:0]           count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q + rd_m_i[PtrW-1:0];
        wr_ptr_d = wr_ptr_q + wr_n_i[PtrW-1:0];
        count_d  = count_q + wr_n_i - rd_m_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives in count_q.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < FetchW; k++) begin
            if (CntW'(k) < wr_n_i) begin
                mem_q[wr_ptr_q + PtrW'(k)] <= wr_data_i[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FetchW; i++) begin
            rd_data_o[i] = mem_q[rd_ptr_q + PtrW'(i)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Multi-wide instruction fetch with circular queue, redirect/flush and drain-aware completion.
// Optional perf counters (perf_fetched, perf_stall) are built when FETCH_PERF_EN is defined.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ROM_BYTES   = 1024,
    parameter int unsigned FETCH_W     = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            rom_size,
    input  logic [ROM_BYTES*8-1:0] instr_rom,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   out_ready,
    output logic [FETCH_W-1:0]     out_valid,
    output logic [FETCH_W*32-1:0]  out_instr,
    output logic [FETCH_W*32-1:0]  out_pc,
    output logic                   fetch_complete
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    localparam int unsigned RomWords = ROM_BYTES / FETCH_INSTR_BYTES;
    localparam int unsigned WordAw   = ptr_width(RomWords);
    localparam int unsigned CntW     = ptr_width(QUEUE_DEPTH + 1);

    logic [31:0]               fetch_pc_q, fetch_pc_d;
    logic                      fc_q, fc_d;
    logic [32:0]               lim, lane_end;
    logic [31:0]               lane_pc [FETCH_W];
    logic [FETCH_W-1:0]        lane_ok;
    logic [CntW-1:0]           nfetch, wr_n, rd_m, deq_n, count, count_next;
    logic                      free_ok;
    fetch_entry_t [FETCH_W-1:0] wr_data, rd_data;
    logic [31:0]               rom_words [RomWords];
    logic                      unused_redirect_pc;

    assign unused_redirect_pc = ^redirect_pc[1:0];

    for (genvar w = 0; w < RomWords; w++) begin : g_rom_words
        assign rom_words[w] = instr_rom[w*32 +: 32];
    end

    always_comb begin
        lim    = ({1'b0, rom_size} < 33'(ROM_BYTES)) ? {1'b0, rom_size} : 33'(ROM_BYTES);
        nfetch = '0;
        lane_end = '0;
        // 33-bit end address keeps PCs near 2^32 from wrapping into range.
        for (int k = 0; k < FETCH_W; k++) begin
            lane_pc[k]        = fetch_pc_q + 32'(FETCH_INSTR_BYTES * k);
            lane_end          = {1'b0, fetch_pc_q} + 33'(FETCH_INSTR_BYTES * (k + 1));
            lane_ok[k]        = (lane_end <= lim);
            wr_data[k].pc     = lane_pc[k];
            wr_data[k].instr  = lane_ok[k] ? rom_words[lane_pc[k][WordAw+1:2]] : '0;
            if (lane_ok[k] && (nfetch == CntW'(k))) begin
                nfetch = nfetch + CntW'(1);
            end
        end

        free_ok = (CntW'(QUEUE_DEPTH) - count) >= CntW'(FETCH_W);
        wr_n    = (!redirect_valid && free_ok) ? nfetch : '0;

        for (int i = 0; i < FETCH_W; i++) begin
            out_valid[i]        = (count > CntW'(i)) && !redirect_valid;
            out_instr[i*32 +: 32] = rd_data[i].instr;
            out_pc[i*32 +: 32]    = rd_data[i].pc;
        end

        deq_n      = (count < CntW'(FETCH_W)) ? count : CntW'(FETCH_W);
        rd_m       = (out_ready && out_valid[0]) ? deq_n : '0;
        count_next = count + wr_n - rd_m;

        fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00}
                                    : fetch_pc_q + {{(30 - CntW){1'b0}}, wr_n, 2'b00};
        fc_d = (({1'b0, fetch_pc_q} + 33'd4) > lim) && (count_next == '0) && !redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            fc_q       <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fc_q       <= fc_d;
        end
    end

    assign fetch_complete = fc_q;

    fetch_ring #(
        .FetchW (FETCH_W),
        .Depth  (QUEUE_DEPTH)
    ) u_ring (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .flush_i   (redirect_valid),
        .wr_n_i    (wr_n),
        .wr_data_i (wr_data),
        .rd_m_i    (rd_m),
        .rd_data_o (rd_data),
        .count_o   (count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall;

    // Stall means work was available but the queue lacked a full bundle of space.
    assign stall = lane_ok[0] && !redirect_valid && !free_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(wr_n);
            perf_stall_q   <= perf_stall_q + 32'(stall);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: expected PC streams queued on reset/redirect, checked on accept.
module tb_fetch_queue_unit;

    localparam int unsigned RomBytes = 1024;
    localparam int unsigned FetchW   = 2;
    localparam int unsigned Depth    = 8;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [31:0]           rom_size;
    logic [RomBytes*8-1:0] instr_rom;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  out_ready;
    logic [FetchW-1:0]     out_valid;
    logic [FetchW*32-1:0]  out_instr;
    logic [FetchW*32-1:0]  out_pc;
    logic                  fetch_complete;
`ifdef FETCH_PERF_EN
    logic [31:0]           perf_fetched, perf_stall;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ROM_BYTES   (RomBytes),
        .FETCH_W     (FetchW),
        .QUEUE_DEPTH (Depth),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_size       (rom_size),
        .instr_rom      (instr_rom),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_complete (fetch_complete)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h5A00_0C0D ^ (pc << 12) ^ (pc >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input logic [31:0] size);
        longint lim = (size < RomBytes) ? longint'(size) : longint'(RomBytes);
        for (longint pc = longint'(start); pc + 4 <= lim; pc += 4) begin
            sb_q.push_back(32'(pc));
        end
    endtask

    // Lanes visible now will be accepted at the coming edge when out_ready is high.
    task automatic consume();
        logic [31:0] exp;
        for (int i = 0; i < FetchW; i++) begin
            if (out_valid[i]) begin
                if (i > 0) check("contig", 32'(out_valid[i-1]), 32'd1);
                if (sb_q.size() == 0) begin
                    check("extra_lane", 32'(out_valid[i]), 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("pc", out_pc[i*32 +: 32], exp);
                    check("instr", out_instr[i*32 +: 32], word_at(exp));
                end
            end
        end
    endtask

    task automatic step();
        #1;
        if (out_ready) consume();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] size, input logic ready);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        rom_size       = size;
        out_ready      = ready;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fc", 32'(fetch_complete), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        sb_q.delete();
        reset_n = 1'b1;
        push_stream(32'h0, size);
    endtask

    task automatic run_until_done(input int bound);
        bit last;
        for (int c = 0; c < bound; c++) begin
            #1;
            if (out_ready) consume();
            last = (sb_q.size() == 0);
            @(posedge clk);
            @(negedge clk);
            if (last) begin
                check("fc_after_drain", 32'(fetch_complete), 32'd1);
                check("drained_valid", 32'(out_valid), 32'd0);
                return;
            end
            check("fc_early", 32'(fetch_complete), 32'd0);
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        rom_size       = 32'd16;
        for (int b = 0; b < RomBytes; b++) begin
            logic [31:0] w;
            w = word_at(32'(b) & 32'hFFFF_FFFC);
            instr_rom[b*8 +: 8] = w[(b % 4)*8 +: 8];
        end
        @(negedge clk);

        // Straight run: bundles {0,4},{8,12}, completion one cycle after last dequeue.
        do_reset(32'd16, 1'b1);
        step();
        check("first_bundle", 32'(out_valid), 32'd3);
        run_until_done(20);

        // Odd tails: 12 and 14 both stop after PC 8.
        for (int t = 0; t < 2; t++) begin
            do_reset((t == 0) ? 32'd12 : 32'd14, 1'b1);
            step();
            check("tail_first", 32'(out_valid), 32'd3);
            step();
            check("tail_valid", 32'(out_valid), 32'd1);
            run_until_done(20);
        end

        // Backpressure: queue fills to 8, fetch holds at 32, drains in order.
        do_reset(32'd64, 1'b0);
        repeat (6) step();
        check("bp_valid", 32'(out_valid), 32'd3);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'd8);
        check("perf_stall", perf_stall, 32'd2);
`endif
        out_ready = 1'b1;
        run_until_done(40);

        // Redirect to 0x10 with 6 queued entries.
        do_reset(32'd64, 1'b0);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        #1;
        check("redir_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        push_stream(32'h10, 32'd64);
        step();
        redirect_valid = 1'b0;
        check("post_redir_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        check("redir_bundle", 32'(out_valid), 32'd3);
        run_until_done(40);

        // Misaligned redirect target behaves as aligned.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        sb_q.delete();
        push_stream(32'h10, 32'd64);
        step();
        redirect_valid = 1'b0;
        run_until_done(40);

        // Redirect beyond lim while non-empty, then back to 0.
        do_reset(32'd64, 1'b0);
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sb_q.delete();
        step();
        redirect_valid = 1'b0;
        check("fc_redir_cycle", 32'(fetch_complete), 32'd0);
        check("beyond_valid", 32'(out_valid), 32'd0);
        step();
        check("fc_beyond", 32'(fetch_complete), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        push_stream(32'h0, 32'd64);
        step();
        redirect_valid = 1'b0;
        check("fc_cleared", 32'(fetch_complete), 32'd0);
        run_until_done(40);

        // rom_size above ROM_BYTES is clamped at the ROM end.
        rom_size       = 32'd2000;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1016;
        sb_q.delete();
        push_stream(32'd1016, 32'd2000);
        step();
        redirect_valid = 1'b0;
        run_until_done(20);

        // PC near 2^32 must not wrap into range.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb_q.delete();
        step();
        redirect_valid = 1'b0;
        step();
        check("fc_nowrap", 32'(fetch_complete), 32'd1);
        check("nowrap_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream discards the queue and restarts at 0.
        do_reset(32'd64, 1'b1);
        step();
        step();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_fc", 32'(fetch_complete), 32'd0);
`ifdef FETCH_PERF_EN
        check("mid_rst_perf", perf_fetched, 32'd0);
`endif
        reset_n = 1'b1;
        sb_q.delete();
        push_stream(32'h0, 32'd64);
        run_until_done(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised multi-wide instruction fetch stage: reads up to FETCH_W little-endian 32-bit instructions per cycle from the flat instruction ROM bus, buffers them with their PCs in a circular fetch queue, and hands in-order bundles to decode over a valid/ready handshake. It sits between the instruction ROM and decode. It adds a redirect/flush path and an end-of-program indication that waits for the queue to drain.

## Interface
- ROM_BYTES, 1024: ROM size in bytes; the ROM bus is ROM_BYTES*8 bits.
- FETCH_W, 2: instructions fetched and presented per cycle; range 1..4.
- QUEUE_DEPTH, 8: queue entries; power of two, at least 2*FETCH_W.
- RESET_PC, 0: PC loaded at reset; must be 4-byte aligned.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- rom_size  in  32  valid program length in bytes.
- instr_rom  in  ROM_BYTES*8  flat ROM; byte b is at bits [b*8 +: 8].
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- out_ready  in  1  decode accepts every valid lane this cycle.
- out_valid  out  FETCH_W  lane i holds a valid instruction; lanes are contiguous from lane 0.
- out_instr  out  FETCH_W*32  lane i instruction at [i*32 +: 32].
- out_pc  out  FETCH_W*32  lane i PC at [i*32 +: 32].
- fetch_complete  out  1  no in-range PC remains and the queue is empty.

## Operation
- Registered state:
  - fetch_pc
  - rd_ptr and wr_ptr, each log2(QUEUE_DEPTH) bits, wrapping modulo QUEUE_DEPTH
  - count, 0..QUEUE_DEPTH
  - fetch_complete
- Effective limit: lim = min(rom_size, ROM_BYTES).
- Lane k is fetchable when fetch_pc + 4k + 4 <= lim. Compare at 33 bits so there is no wraparound.
- Enqueue:
  - Condition: redirect_valid = 0 and QUEUE_DEPTH - count >= FETCH_W, using the registered count without dequeue credit.
  - Writes n = number of fetchable lanes (0..FETCH_W), where lane k holds instr_rom[(fetch_pc+4k)*8 +: 32] and pc fetch_pc+4k.
  - Advances fetch_pc by 4n and wr_ptr by n.
- Dequeue:
  - out_valid[i] = (count > i) and not redirect_valid. This is a documented combinational path from redirect_valid.
  - Lane i shows entry rd_ptr+i.
  - Condition: out_ready = 1 and out_valid[0] = 1.
  - Removes m = popcount(out_valid) entries and advances rd_ptr by m.
- count is updated with count + n - m when both enqueue and dequeue occur in the same cycle.
- Redirect has priority over everything:
  - rd_ptr = wr_ptr = count = 0
  - fetch_pc = {redirect_pc[31:2], 2'b00}
  - no enqueue and no dequeue that cycle
- fetch_complete:
  - Next value = (fetch_pc + 4 > lim) and (count + n - m == 0) and not redirect_valid.
  - It deasserts the cycle after a redirect to an in-range PC.
- Out-of-range PC: a PC of ROM_BYTES or more never indexes instr_rom; the lane is treated as not fetchable.
- rom_size changing mid-run takes effect on the next cycle's evaluation.

## Timing
- Reset (reset_n = 0 at an edge) sets fetch_pc = RESET_PC, pointers and count = 0, and fetch_complete = 0. out_valid = 0 combinationally from count = 0.
- Latency: an instruction enqueued at edge N appears on out_* after edge N; first out_valid is 1 cycle after reset release.
- Throughput: FETCH_W instructions per cycle sustained when out_ready = 1 and QUEUE_DEPTH >= 2*FETCH_W.
- Full: the enqueue stalls while free slots < FETCH_W; a partial bundle is never written.
- Reset asserted mid-operation discards all queued entries at that edge.

## Configuration
- FETCH_PERF_EN defined:
  - adds output perf_fetched (32 bits), which counts instructions enqueued
  - adds output perf_stall (32 bits), which counts cycles with a fetchable lane 0 but the enqueue blocked by full
  - both counters wrap, reset to 0, and are not cleared by redirect
- FETCH_PERF_EN undefined: the ports and counters are absent.

## Structure
- Package fetch_pkg:
  - FETCH_INSTR_BYTES = 4
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
  - function clog2-safe pointer width
- Sub-module fetch_ring: a circular buffer of fetch_entry_t with FETCH_W-wide write and read ports, n/m counts, and a flush.
- The top level holds fetch_pc, the limit logic, ROM lane extraction, and fetch_complete.

## Test plan
- Straight run, FETCH_W=2, rom_size=16, out_ready=1: two bundles with PCs {0,4} and {8,12}. fetch_complete = 1 on the cycle after the last dequeue.
- Odd tail, rom_size=12: the second bundle has out_valid=2'b01 with PC 8. rom_size=14 gives the same result, because the partial word is not fetched.
- Backpressure, out_ready=0, QUEUE_DEPTH=8, FETCH_W=2: count reaches 8, the enqueue stalls, and fetch_pc holds at 32. Releasing out_ready drains the queue in order 0..28.
- Redirect to 0x10 while 6 entries are queued: out_valid = 0 that cycle. The next bundle after one cycle has PCs {0x10,0x14}. A redirect to 0x13 behaves as 0x10.
- Redirect beyond lim with the queue non-empty: the queue is flushed and fetch_complete = 1 on the following cycle. A later redirect to 0 clears it.
- Reset asserted mid-stream: all outputs return to reset values at that edge and fetch restarts at RESET_PC. With FETCH_PERF_EN defined, the perf counters read 0.
